// File: rtl/conv_2d_stream_pkg.sv
// Shared definitions for the 2-D convolution engines: FSM encoding,
// default widths and a constant-capable ceil(log2) helper.
package conv_2d_stream_pkg;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } conv_state_e;

  localparam int KSIZE_DEF     = 3;
  localparam int NB_DATA_DEF   = 8;
  localparam int NBF_DATA_DEF  = 7;
  localparam int NB_COEFF_DEF  = 8;
  localparam int NBF_COEFF_DEF = 7;
  localparam int NB_OUT_DEF    = 8;
  localparam int NBF_OUT_DEF   = 7;

  // ceil(log2(value)); 0 for value <= 1
  function automatic int clog2_int(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/conv_2d_stream_mac_tree.sv
// Two-stage KxK MAC: stage 1 registers the products, stage 2 registers the
// exact sum after round-half-up and saturation. o_pixel holds when not enabled.
module conv_2d_stream_mac_tree
  import conv_2d_stream_pkg::*;
#(
  parameter int KSIZE     = KSIZE_DEF,
  parameter int NB_DATA   = NB_DATA_DEF,
  parameter int NBF_DATA  = NBF_DATA_DEF,
  parameter int NB_COEFF  = NB_COEFF_DEF,
  parameter int NBF_COEFF = NBF_COEFF_DEF,
  parameter int NB_OUT    = NB_OUT_DEF,
  parameter int NBF_OUT   = NBF_OUT_DEF
) (
  input  logic                           clk,
  input  logic                           i_nrst,
  input  logic                           i_prod_en,
  input  logic [KSIZE*KSIZE*NB_DATA-1:0]  i_win,
  input  logic [KSIZE*KSIZE*NB_COEFF-1:0] i_knl,
  input  logic                           i_out_en,
  output logic [NB_OUT-1:0]              o_pixel
);

  localparam int KK      = KSIZE * KSIZE;
  localparam int NB_PROD = NB_DATA + NB_COEFF;
  localparam int NB_ACC  = NB_PROD + clog2_int(KK);
  localparam int SH      = NBF_DATA + NBF_COEFF - NBF_OUT;

  localparam logic signed [NB_ACC-1:0] SAT_MAX = {{(NB_ACC-NB_OUT+1){1'b0}}, {(NB_OUT-1){1'b1}}};
  localparam logic signed [NB_ACC-1:0] SAT_MIN = {{(NB_ACC-NB_OUT+1){1'b1}}, {(NB_OUT-1){1'b0}}};

  logic signed [NB_PROD-1:0] r_prod [KK];
  logic signed [NB_ACC-1:0]  w_acc;
  logic signed [NB_ACC-1:0]  w_rnd;
  logic [NB_OUT-1:0]         w_sat;
  logic [NB_OUT-1:0]         r_pixel;

  // stage 1: register every window x kernel product on an accepted pixel beat
  always_ff @(posedge clk or negedge i_nrst) begin
    if (!i_nrst) begin
      for (int i = 0; i < KK; i++) r_prod[i] <= '0;
    end else if (i_prod_en) begin
      for (int i = 0; i < KK; i++) begin
        r_prod[i] <= NB_PROD'($signed(i_win[i*NB_DATA +: NB_DATA]))
                   * NB_PROD'($signed(i_knl[i*NB_COEFF +: NB_COEFF]));
      end
    end
  end

  // exact accumulation: headroom of clog2(K*K) bits means no wrap
  always_comb begin
    w_acc = '0;
    for (int i = 0; i < KK; i++) w_acc = w_acc + NB_ACC'(r_prod[i]);
  end

  generate
    if (SH > 0) begin : g_rnd
      assign w_rnd = (w_acc + (NB_ACC'(1) <<< (SH - 1))) >>> SH;
    end else begin : g_nornd
      assign w_rnd = w_acc;
    end
  endgenerate

  // clamp the rounded value into the signed output range
  always_comb begin
    w_sat = w_rnd[NB_OUT-1:0];
    if (w_rnd > SAT_MAX)      w_sat = {1'b0, {(NB_OUT-1){1'b1}}};
    else if (w_rnd < SAT_MIN) w_sat = {1'b1, {(NB_OUT-1){1'b0}}};
  end

  // stage 2: output register, updated only for surviving results
  always_ff @(posedge clk or negedge i_nrst) begin
    if (!i_nrst)       r_pixel <= '0;
    else if (i_out_en) r_pixel <= w_sat;
  end

  assign o_pixel = r_pixel;

endmodule

// File: rtl/conv_2d_stream.sv
// KxK streaming convolution: kernel load FSM, sliding window, valid pipeline.
//
// state   | meaning
// ST_LOAD | kernel columns written at col_cnt; pixel beats dropped
// ST_RUN  | kernel complete; pixel beats shift the window and feed the MAC
module conv_2d_stream
  import conv_2d_stream_pkg::*;
#(
  parameter int KSIZE     = KSIZE_DEF,
  parameter int NB_DATA   = NB_DATA_DEF,
  parameter int NBF_DATA  = NBF_DATA_DEF,
  parameter int NB_COEFF  = NB_COEFF_DEF,
  parameter int NBF_COEFF = NBF_COEFF_DEF,
  parameter int NB_OUT    = NB_OUT_DEF,
  parameter int NBF_OUT   = NBF_OUT_DEF
) (
  input  logic                     clk,
  input  logic                     i_nrst,
  input  logic                     i_load_knl,
  input  logic                     i_valid,
  input  logic                     i_sol,
  input  logic [KSIZE*NB_DATA-1:0] i_data,
  output logic                     o_knl_ready,
  output logic                     o_valid,
  output logic [NB_OUT-1:0]        o_pixel
);

  localparam int KK      = KSIZE * KSIZE;
  localparam int NB_COL  = clog2_int(KSIZE);
  localparam int NB_FILL = clog2_int(KSIZE + 1);

  conv_state_e          r_state;
  logic [NB_COL-1:0]    r_col_cnt;
  logic [NB_FILL-1:0]   r_fill_cnt;
  logic [NB_FILL-1:0]   w_fill_next;
  logic                 r_knl_ready;
  logic                 r_vld1;
  logic                 r_vld2;
  logic                 w_knl_beat;
  logic                 w_pix_beat;
  logic                 w_reload;
  logic                 w_result_beat;
  logic                 w_out_en;
  logic [NB_COL-1:0]    w_knl_col;

  logic [NB_DATA-1:0]   r_win      [KSIZE][KSIZE];
  logic [NB_DATA-1:0]   w_win_next [KSIZE][KSIZE];
  logic [NB_COEFF-1:0]  r_knl      [KSIZE][KSIZE];
  logic [KK*NB_DATA-1:0]  w_win_flat;
  logic [KK*NB_COEFF-1:0] w_knl_flat;

  assign w_knl_beat    = i_valid & i_load_knl;
  assign w_pix_beat    = i_valid & ~i_load_knl & (r_state == ST_RUN);
  assign w_reload      = w_knl_beat & (r_state == ST_RUN);
  // a reload beat in RUN is always kernel column 0
  assign w_knl_col     = (r_state == ST_RUN) ? '0 : r_col_cnt;
  assign w_result_beat = w_pix_beat & (w_fill_next == NB_FILL'(KSIZE));
  assign w_out_en      = r_vld1 & ~w_reload;

  // fill count after a pixel beat: restart on i_sol, saturate at K
  always_comb begin
    w_fill_next = r_fill_cnt;
    if (i_sol)                                w_fill_next = NB_FILL'(1);
    else if (r_fill_cnt != NB_FILL'(KSIZE))   w_fill_next = r_fill_cnt + NB_FILL'(1);
  end

  // window after the current beat: new column at 0, older columns move right
  always_comb begin
    for (int r = 0; r < KSIZE; r++) begin
      w_win_next[r][0] = i_data[r*NB_DATA +: NB_DATA];
      for (int j = 1; j < KSIZE; j++) w_win_next[r][j] = r_win[r][j-1];
    end
  end

  // flatten window and kernel for the MAC tree, index = r*K + j
  always_comb begin
    w_win_flat = '0;
    w_knl_flat = '0;
    for (int r = 0; r < KSIZE; r++) begin
      for (int j = 0; j < KSIZE; j++) begin
        w_win_flat[(r*KSIZE+j)*NB_DATA +: NB_DATA]   = w_win_next[r][j];
        w_knl_flat[(r*KSIZE+j)*NB_COEFF +: NB_COEFF] = r_knl[r][j];
      end
    end
  end

  // kernel load / run FSM with column and fill counters
  always_ff @(posedge clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_state     <= ST_LOAD;
      r_col_cnt   <= '0;
      r_fill_cnt  <= '0;
      r_knl_ready <= 1'b0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (w_knl_beat) begin
            if (r_col_cnt == NB_COL'(KSIZE - 1)) begin
              r_state     <= ST_RUN;
              r_col_cnt   <= '0;
              r_knl_ready <= 1'b1;
            end else begin
              r_col_cnt <= r_col_cnt + NB_COL'(1);
            end
          end
        end
        ST_RUN: begin
          if (w_reload) begin
            r_state     <= ST_LOAD;
            r_col_cnt   <= NB_COL'(1);
            r_fill_cnt  <= '0;
            r_knl_ready <= 1'b0;
          end else if (w_pix_beat) begin
            r_fill_cnt <= w_fill_next;
          end
        end
        default: begin
          r_state     <= ST_LOAD;
          r_col_cnt   <= '0;
          r_fill_cnt  <= '0;
          r_knl_ready <= 1'b0;
        end
      endcase
    end
  end

  // kernel column write, low NB_COEFF bits of each row
  always_ff @(posedge clk or negedge i_nrst) begin
    if (!i_nrst) begin
      for (int r = 0; r < KSIZE; r++)
        for (int j = 0; j < KSIZE; j++) r_knl[r][j] <= '0;
    end else if (w_knl_beat) begin
      for (int r = 0; r < KSIZE; r++) r_knl[r][w_knl_col] <= i_data[r*NB_DATA +: NB_COEFF];
    end
  end

  // window shift on accepted pixel beats
  always_ff @(posedge clk or negedge i_nrst) begin
    if (!i_nrst) begin
      for (int r = 0; r < KSIZE; r++)
        for (int j = 0; j < KSIZE; j++) r_win[r][j] <= '0;
    end else if (w_pix_beat) begin
      for (int r = 0; r < KSIZE; r++)
        for (int j = 0; j < KSIZE; j++) r_win[r][j] <= w_win_next[r][j];
    end
  end

  // valid pipeline tracking the two MAC stages; a reload beat kills stage 1
  always_ff @(posedge clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_vld1 <= 1'b0;
      r_vld2 <= 1'b0;
    end else begin
      r_vld1 <= w_result_beat;
      r_vld2 <= w_out_en;
    end
  end

  conv_2d_stream_mac_tree #(
    .KSIZE    (KSIZE),
    .NB_DATA  (NB_DATA),
    .NBF_DATA (NBF_DATA),
    .NB_COEFF (NB_COEFF),
    .NBF_COEFF(NBF_COEFF),
    .NB_OUT   (NB_OUT),
    .NBF_OUT  (NBF_OUT)
  ) u_mac (
    .clk      (clk),
    .i_nrst   (i_nrst),
    .i_prod_en(w_pix_beat),
    .i_win    (w_win_flat),
    .i_knl    (w_knl_flat),
    .i_out_en (w_out_en),
    .o_pixel  (o_pixel)
  );

  assign o_knl_ready = r_knl_ready;
  assign o_valid     = r_vld2;

endmodule

// File: tb/tb_conv_2d_stream.sv
// Directed bench for conv_2d_stream at defaults (K=3, Q1.7 in/out).
// Each step drives one cycle of inputs, then checks o_valid/o_pixel 1 time
// unit after the edge; the result of a beat appears after the next step.
module tb_conv_2d_stream;

  logic        clk;
  logic        i_nrst;
  logic        i_load_knl;
  logic        i_valid;
  logic        i_sol;
  logic [23:0] i_data;
  logic        o_knl_ready;
  logic        o_valid;
  logic [7:0]  o_pixel;

  int n_err;
  int n_chk;

  conv_2d_stream dut (
    .clk        (clk),
    .i_nrst     (i_nrst),
    .i_load_knl (i_load_knl),
    .i_valid    (i_valid),
    .i_sol      (i_sol),
    .i_data     (i_data),
    .o_knl_ready(o_knl_ready),
    .o_valid    (o_valid),
    .o_pixel    (o_pixel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // drive one cycle, then check the registered outputs after the edge
  task automatic step(input string tag, input logic v, input logic l, input logic s,
                      input logic [23:0] d, input logic ev, input logic [7:0] ep);
    i_valid    = v;
    i_load_knl = l;
    i_sol      = s;
    i_data     = d;
    @(posedge clk);
    #1;
    chk({tag, ".valid"}, {31'b0, o_valid}, {31'b0, ev});
    chk({tag, ".pixel"}, {24'b0, o_pixel}, {24'b0, ep});
  endtask

  task automatic chk_rdy(input string tag, input logic exp);
    chk({tag, ".ready"}, {31'b0, o_knl_ready}, {31'b0, exp});
  endtask

  initial begin
    n_err = 0;
    n_chk = 0;
    clk = 1'b0;
    i_nrst = 1'b0;
    i_valid = 1'b0;
    i_load_knl = 1'b0;
    i_sol = 1'b0;
    i_data = '0;

    // reset state
    #12;
    chk("rst.valid", {31'b0, o_valid}, 32'd0);
    chk("rst.pixel", {24'b0, o_pixel}, 32'd0);
    chk_rdy("rst", 1'b0);
    #1 i_nrst = 1'b1;

    // pixel beat in LOAD is dropped
    step("t1.drop", 1, 0, 0, 24'h404040, 0, 8'h00); chk_rdy("t1.drop", 0);
    // kernel: centre 0x40
    step("t1.k1", 1, 1, 0, 24'h000000, 0, 8'h00);
    step("t1.k2", 1, 1, 0, 24'h004000, 0, 8'h00); chk_rdy("t1.k2", 0);
    step("t1.k3", 1, 1, 0, 24'h000000, 0, 8'h00); chk_rdy("t1.k3", 1);
    step("t1.p1", 1, 0, 1, 24'h404040, 0, 8'h00);
    step("t1.p2", 1, 0, 0, 24'h404040, 0, 8'h00);
    step("t1.p3", 1, 0, 0, 24'h404040, 0, 8'h00);
    step("t1.o1", 0, 0, 0, 24'h000000, 1, 8'h20);
    step("t1.o2", 0, 0, 0, 24'h000000, 0, 8'h20);

    // rounding: reload centre 0x01 from RUN, stray pixel beat in between
    step("t3.k1", 1, 1, 0, 24'h000000, 0, 8'h20); chk_rdy("t3.k1", 0);
    step("t3.k2", 1, 1, 0, 24'h000100, 0, 8'h20);
    step("t3.drop", 1, 0, 0, 24'h7F7F7F, 0, 8'h20); chk_rdy("t3.drop", 0);
    step("t3.k3", 1, 1, 0, 24'h000000, 0, 8'h20); chk_rdy("t3.k3", 1);
    step("t3.p1", 1, 0, 1, 24'h404040, 0, 8'h20);
    step("t3.p2", 1, 0, 0, 24'h404040, 0, 8'h20);
    step("t3.p3", 1, 0, 0, 24'h404040, 0, 8'h20);
    step("t3.p4", 1, 0, 0, 24'h3F3F3F, 1, 8'h01);
    step("t3.p5", 1, 0, 0, 24'hC0C0C0, 1, 8'h01);
    step("t3.p6", 1, 0, 0, 24'h000000, 1, 8'h00);
    step("t3.o1", 0, 0, 0, 24'h000000, 1, 8'h00);
    step("t3.o2", 0, 0, 0, 24'h000000, 0, 8'h00);

    // saturation: all coefficients 0x7F
    step("t2.k1", 1, 1, 0, 24'h7F7F7F, 0, 8'h00);
    step("t2.k2", 1, 1, 0, 24'h7F7F7F, 0, 8'h00);
    step("t2.k3", 1, 1, 0, 24'h7F7F7F, 0, 8'h00); chk_rdy("t2.k3", 1);
    step("t2.p1", 1, 0, 1, 24'h7F7F7F, 0, 8'h00);
    step("t2.p2", 1, 0, 0, 24'h7F7F7F, 0, 8'h00);
    step("t2.p3", 1, 0, 0, 24'h7F7F7F, 0, 8'h00);
    step("t2.p4", 1, 0, 0, 24'h808080, 1, 8'h7F);
    step("t2.p5", 1, 0, 0, 24'h808080, 1, 8'h7F);
    step("t2.p6", 1, 0, 0, 24'h808080, 1, 8'h80);
    step("t2.o1", 0, 0, 0, 24'h000000, 1, 8'h80);
    step("t2.o2", 0, 0, 0, 24'h000000, 0, 8'h80);

    // streaming: k[0][0]=0x40 (col 0, row 0), k[2][2]=0x20 (col 2, row 2)
    // column n = {n*16, 0, n*16}; result = 12n-8 for a full window
    step("t4.k1", 1, 1, 0, 24'h000040, 0, 8'h80);
    step("t4.k2", 1, 1, 0, 24'h000000, 0, 8'h80);
    step("t4.k3", 1, 1, 0, 24'h200000, 0, 8'h80); chk_rdy("t4.k3", 1);
    step("t4a.p1", 1, 0, 1, 24'h100010, 0, 8'h80);
    step("t4a.p2", 1, 0, 0, 24'h200020, 0, 8'h80);
    step("t4a.p3", 1, 0, 0, 24'h300030, 0, 8'h80);
    step("t4a.p4", 1, 0, 0, 24'h400040, 1, 8'h1C);
    step("t4a.p5", 1, 0, 0, 24'h500050, 1, 8'h28);
    step("t4a.p6", 1, 0, 0, 24'h600060, 1, 8'h34);
    step("t4a.o1", 0, 0, 0, 24'h000000, 1, 8'h40);
    step("t4a.o2", 0, 0, 0, 24'h000000, 0, 8'h40);
    // second line: bubble after beat 3, i_sol again on beat 5
    step("t4b.p1", 1, 0, 1, 24'h100010, 0, 8'h40);
    step("t4b.p2", 1, 0, 0, 24'h200020, 0, 8'h40);
    step("t4b.p3", 1, 0, 0, 24'h300030, 0, 8'h40);
    step("t4b.bub", 0, 0, 0, 24'h000000, 1, 8'h1C);
    step("t4b.p4", 1, 0, 0, 24'h400040, 0, 8'h1C);
    step("t4b.p5", 1, 0, 1, 24'h500050, 1, 8'h28);
    step("t4b.p6", 1, 0, 0, 24'h600060, 0, 8'h28);
    step("t4b.p7", 1, 0, 0, 24'h700070, 0, 8'h28);
    step("t4b.o1", 0, 0, 0, 24'h000000, 1, 8'h4C);
    step("t4b.o2", 0, 0, 0, 24'h000000, 0, 8'h4C);

    // reload right behind a result beat: that result must never appear
    step("t5.px", 1, 0, 0, 24'h400040, 0, 8'h4C);
    step("t5.k1", 1, 1, 0, 24'h000000, 0, 8'h4C); chk_rdy("t5.k1", 0);
    step("t5.k2", 1, 1, 0, 24'h004000, 0, 8'h4C); chk_rdy("t5.k2", 0);
    step("t5.k3", 1, 1, 0, 24'h000000, 0, 8'h4C); chk_rdy("t5.k3", 1);
    step("t5.p1", 1, 0, 1, 24'h404040, 0, 8'h4C);
    step("t5.p2", 1, 0, 0, 24'h404040, 0, 8'h4C);
    step("t5.p3", 1, 0, 0, 24'h404040, 0, 8'h4C);
    step("t5.p4", 1, 0, 0, 24'h404040, 1, 8'h20);

    // async reset between edges with a result visible and one in flight
    i_nrst = 1'b0;
    #1;
    chk("t6.rst.valid", {31'b0, o_valid}, 32'd0);
    chk("t6.rst.pixel", {24'b0, o_pixel}, 32'd0);
    chk_rdy("t6.rst", 0);
    #1 i_nrst = 1'b1;
    step("t6.p1", 1, 0, 1, 24'h404040, 0, 8'h00); chk_rdy("t6.p1", 0);
    step("t6.p2", 1, 0, 0, 24'h404040, 0, 8'h00);
    step("t6.p3", 1, 0, 0, 24'h404040, 0, 8'h00);
    step("t6.o1", 0, 0, 0, 24'h000000, 0, 8'h00); chk_rdy("t6.o1", 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
